// File: rtl/pc_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | pc_unit_pkg : shared types and codes for the PC update unit                 |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package pc_unit_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      EXC_EPC = 2'd1,
      EXC_VEC = 2'd2
   } pc_state_e;

   localparam logic [1:0] CAUSE_OPCODE = 2'b00;
   localparam logic [1:0] CAUSE_OVFL   = 2'b01;
   localparam logic [1:0] CAUSE_DIVZ   = 2'b10;
   localparam logic [1:0] CAUSE_ALIGN  = 2'b11;

   localparam logic [1:0] BR_EQ = 2'b00;
   localparam logic [1:0] BR_NE = 2'b01;
   localparam logic [1:0] BR_LE = 2'b10;
   localparam logic [1:0] BR_GT = 2'b11;

endpackage

`default_nettype wire

// File: rtl/pc_update_unit_if.sv
// +----------------------------------------------------------------------------+
// | pc_update_unit_if : PC-mux / branch / exception bus of the PC update unit   |
// | Revision          : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pc_update_unit_if;
   logic [31:0] next_pc;
   logic        pc_write;
   logic        pc_write_cond;
   logic [1:0]  branch_op;
   logic        alu_zero;
   logic        alu_lt;
   logic        exc_req;
   logic [1:0]  exc_cause;
   logic [31:0] pc;
   logic [31:0] epc;
   logic        exc_busy;
   logic        exc_ack;

   modport master (
      output next_pc, pc_write, pc_write_cond, branch_op, alu_zero, alu_lt,
             exc_req, exc_cause,
      input  pc, epc, exc_busy, exc_ack
   );

   modport slave (
      input  next_pc, pc_write, pc_write_cond, branch_op, alu_zero, alu_lt,
             exc_req, exc_cause,
      output pc, epc, exc_busy, exc_ack
   );
endinterface

`default_nettype wire

// File: rtl/branch_cond_eval.sv
// +----------------------------------------------------------------------------+
// | branch_cond_eval : combinational branch-taken decision from ALU flags       |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module branch_cond_eval
   import pc_unit_pkg::*;
(
   input  logic [1:0] branch_op_i,
   input  logic       alu_zero_i,
   input  logic       alu_lt_i,
   output logic       take_o
);

   always_comb begin
      take_o = 1'b0;
      case (branch_op_i)
         BR_EQ:   take_o = alu_zero_i;
         BR_NE:   take_o = ~alu_zero_i;
         BR_LE:   take_o = alu_zero_i | alu_lt_i;
         BR_GT:   take_o = ~alu_zero_i & ~alu_lt_i;
         default: take_o = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/pc_update_unit.sv
// +----------------------------------------------------------------------------+
// | pc_update_unit : PC/EPC registers with a three-state exception sequencer    |
// | Option         : PC_ALIGN_CHECK_EN traps misaligned PC writes (cause 11)    |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_update_unit
   import pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] VEC_OPCODE = 32'h0000_00FD,
   parameter logic [31:0] VEC_OVFL   = 32'h0000_00FE,
   parameter logic [31:0] VEC_DIVZ   = 32'h0000_00FF,
   parameter logic [31:0] VEC_ALIGN  = 32'h0000_00FC
) (
   input  logic              clk,
   input  logic              reset,
   pc_update_unit_if.slave   bus
);

   pc_state_e   state_q;
   logic [31:0] pc_q;
   logic [31:0] epc_q;
   logic        busy_q;
   logic        ack_q;
   logic [1:0]  cause_q;

   logic        w_take;
   logic        w_we;
   logic        w_exc_start;
   logic        w_wr_ok;
   logic [1:0]  w_cause_sel;

   branch_cond_eval u_branch_cond_eval (
      .branch_op_i (bus.branch_op),
      .alu_zero_i  (bus.alu_zero),
      .alu_lt_i    (bus.alu_lt),
      .take_o      (w_take)
   );

   assign w_we = bus.pc_write | (bus.pc_write_cond & w_take);

`ifdef PC_ALIGN_CHECK_EN
   logic w_misalign;
   assign w_misalign  = w_we & (|bus.next_pc[1:0]);
   assign w_exc_start = bus.exc_req | w_misalign;
   // An external request outranks the internally detected misalignment.
   assign w_cause_sel = bus.exc_req ? bus.exc_cause : CAUSE_ALIGN;
   assign w_wr_ok     = w_we & ~w_misalign;
`else
   logic w_unused_vec_align;
   assign w_unused_vec_align = ^VEC_ALIGN;
   assign w_exc_start = bus.exc_req;
   assign w_cause_sel = bus.exc_cause;
   assign w_wr_ok     = w_we;
`endif

   function automatic logic [31:0] vec_for(input logic [1:0] cause);
      logic [31:0] v;
      case (cause)
         CAUSE_OVFL:  v = VEC_OVFL;
         CAUSE_DIVZ:  v = VEC_DIVZ;
`ifdef PC_ALIGN_CHECK_EN
         CAUSE_ALIGN: v = VEC_ALIGN;
`else
         CAUSE_ALIGN: v = VEC_OPCODE;
`endif
         default:     v = VEC_OPCODE;
      endcase
      return v;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         epc_q   <= 32'h0000_0000;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         cause_q <= CAUSE_OPCODE;
      end else begin
         case (state_q)
            RUN: begin
               ack_q <= 1'b0;
               // Exception entry drops any write requested in the same cycle.
               if (w_exc_start) begin
                  cause_q <= w_cause_sel;
                  busy_q  <= 1'b1;
                  state_q <= EXC_EPC;
               end else if (w_wr_ok) begin
                  pc_q <= bus.next_pc;
               end
            end
            EXC_EPC: begin
               epc_q   <= pc_q - 32'd4;
               state_q <= EXC_VEC;
            end
            EXC_VEC: begin
               pc_q    <= vec_for(cause_q);
               busy_q  <= 1'b0;
               ack_q   <= 1'b1;
               state_q <= RUN;
            end
            default: begin
               state_q <= RUN;
               busy_q  <= 1'b0;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc       = pc_q;
   assign bus.epc      = epc_q;
   assign bus.exc_busy = busy_q;
   assign bus.exc_ack  = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_update_unit.sv
// +----------------------------------------------------------------------------+
// | tb_pc_update_unit : directed stimulus with a cycle-tagged scoreboard        |
// | Revision          : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pc_update_unit;
   import pc_unit_pkg::*;

   logic clk = 1'b0;
   logic reset;

   pc_update_unit_if bus();

   pc_update_unit #(
      .RESET_PC   (32'h0000_0000),
      .VEC_OPCODE (32'h0000_00FD),
      .VEC_OVFL   (32'h0000_00FE),
      .VEC_DIVZ   (32'h0000_00FF),
      .VEC_ALIGN  (32'h0000_00FC)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int unsigned r_edge = 0;
   always @(posedge clk) r_edge <= r_edge + 1;

   typedef struct {
      int unsigned  tag;
      logic [95:0]  name;
      logic [31:0]  pc;
      logic [31:0]  epc;
      logic         busy;
      logic         ack;
   } exp_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] epc;
   } ack_t;

   exp_t exp_q[$];
   ack_t ack_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic cmp(input logic [95:0] nm, input logic [31:0] pc, input logic [31:0] epc,
                      input logic busy, input logic ack);
      n_vec++;
      if (bus.pc !== pc || bus.epc !== epc || bus.exc_busy !== busy || bus.exc_ack !== ack) begin
         n_miss++;
         $display("FAIL %0s: got pc=%h epc=%h busy=%b ack=%b, want pc=%h epc=%h busy=%b ack=%b",
                  nm, bus.pc, bus.epc, bus.exc_busy, bus.exc_ack, pc, epc, busy, ack);
      end
   endtask

   task automatic expect_at(input int unsigned tag, input logic [95:0] nm, input logic [31:0] pc,
                            input logic [31:0] epc, input logic busy, input logic ack);
      exp_t e;
      e.tag = tag; e.name = nm; e.pc = pc; e.epc = epc; e.busy = busy; e.ack = ack;
      exp_q.push_back(e);
   endtask

   task automatic expect_ack(input logic [31:0] pc, input logic [31:0] epc);
      ack_t a;
      a.pc = pc; a.epc = epc;
      ack_q.push_back(a);
   endtask

   task automatic set_in(input logic [31:0] npc, input logic pw, input logic pwc,
                         input logic [1:0] bop, input logic z, input logic lt,
                         input logic er, input logic [1:0] ec);
      bus.next_pc       = npc;
      bus.pc_write      = pw;
      bus.pc_write_cond = pwc;
      bus.branch_op     = bop;
      bus.alu_zero      = z;
      bus.alu_lt        = lt;
      bus.exc_req       = er;
      bus.exc_cause     = ec;
   endtask

   // Monitor: scoreboard entries are released at the falling edge after their tagged rising edge.
   always @(negedge clk) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].tag == r_edge) begin
            cmp(exp_q[i].name, exp_q[i].pc, exp_q[i].epc, exp_q[i].busy, exp_q[i].ack);
            exp_q.delete(i);
         end else if (exp_q[i].tag < r_edge) begin
            n_vec++;
            n_miss++;
            $display("FAIL %0s: check skipped at edge %0d, want edge %0d", exp_q[i].name, r_edge, exp_q[i].tag);
            exp_q.delete(i);
         end
      end
      if (bus.exc_ack === 1'b1) begin
         n_vec++;
         if (ack_q.size() == 0) begin
            n_miss++;
            $display("FAIL ack_pulse: got unexpected ack with pc=%h epc=%h, want no ack", bus.pc, bus.epc);
         end else begin
            ack_t a;
            a = ack_q.pop_front();
            if (bus.pc !== a.pc || bus.epc !== a.epc) begin
               n_miss++;
               $display("FAIL ack_pulse: got pc=%h epc=%h, want pc=%h epc=%h", bus.pc, bus.epc, a.pc, a.epc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by time limit, want completion");
      $fatal(1);
   end

   initial begin
      int unsigned n;
      reset = 1'b0;
      set_in(32'h0, 1'b0, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b0, 2'b00);

      @(negedge clk);
      expect_at(r_edge + 1, "rst", 32'h0, 32'h0, 1'b0, 1'b0);

      @(negedge clk); n = r_edge + 1;
      reset = 1'b1;
      set_in(32'h10, 1'b1, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b0, 2'b00);
      expect_at(n, "wr10", 32'h10, 32'h0, 1'b0, 1'b0);

      // Conditional writes, one per branch kind and polarity.
      @(negedge clk); n = r_edge + 1;
      set_in(32'h40, 1'b0, 1'b1, BR_NE, 1'b1, 1'b0, 1'b0, 2'b00);
      expect_at(n, "bne_nt", 32'h10, 32'h0, 1'b0, 1'b0);
      @(negedge clk); n = r_edge + 1;
      set_in(32'h40, 1'b0, 1'b1, BR_GT, 1'b0, 1'b0, 1'b0, 2'b00);
      expect_at(n, "bgt_t", 32'h40, 32'h0, 1'b0, 1'b0);
      @(negedge clk); n = r_edge + 1;
      set_in(32'h48, 1'b0, 1'b1, BR_EQ, 1'b1, 1'b0, 1'b0, 2'b00);
      expect_at(n, "beq_t", 32'h48, 32'h0, 1'b0, 1'b0);
      @(negedge clk); n = r_edge + 1;
      set_in(32'h50, 1'b0, 1'b1, BR_LE, 1'b0, 1'b1, 1'b0, 2'b00);
      expect_at(n, "ble_t", 32'h50, 32'h0, 1'b0, 1'b0);
      @(negedge clk); n = r_edge + 1;
      set_in(32'h54, 1'b0, 1'b1, BR_LE, 1'b0, 1'b0, 1'b0, 2'b00);
      expect_at(n, "ble_nt", 32'h50, 32'h0, 1'b0, 1'b0);
      @(negedge clk); n = r_edge + 1;
      set_in(32'h58, 1'b0, 1'b1, BR_GT, 1'b0, 1'b1, 1'b0, 2'b00);
      expect_at(n, "bgt_nt", 32'h50, 32'h0, 1'b0, 1'b0);
      @(negedge clk); n = r_edge + 1;
      set_in(32'h24, 1'b0, 1'b1, BR_NE, 1'b0, 1'b0, 1'b0, 2'b00);
      expect_at(n, "bne_t", 32'h24, 32'h0, 1'b0, 1'b0);
      @(negedge clk); n = r_edge + 1;
      set_in(32'h99, 1'b0, 1'b0, BR_EQ, 1'b1, 1'b0, 1'b0, 2'b00);
      expect_at(n, "nocond", 32'h24, 32'h0, 1'b0, 1'b0);

      // Overflow exception from pc=0x24.
      @(negedge clk); n = r_edge + 1;
      set_in(32'h0, 1'b0, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b1, CAUSE_OVFL);
      expect_at(n,     "ov_busy", 32'h24, 32'h0,  1'b1, 1'b0);
      expect_at(n + 1, "ov_epc",  32'h24, 32'h20, 1'b1, 1'b0);
      expect_at(n + 2, "ov_vec",  32'hFE, 32'h20, 1'b0, 1'b1);
      expect_at(n + 3, "ov_fall", 32'hFE, 32'h20, 1'b0, 1'b0);
      expect_ack(32'hFE, 32'h20);
      @(negedge clk);
      set_in(32'h0, 1'b0, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b0, 2'b00);
      repeat (2) @(negedge clk);

      // Divide-by-zero racing a write, then nested requests while busy.
      @(negedge clk); n = r_edge + 1;
      set_in(32'h80, 1'b1, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b1, CAUSE_DIVZ);
      expect_at(n,     "dz_busy", 32'hFE, 32'h20, 1'b1, 1'b0);
      expect_at(n + 1, "dz_epc",  32'hFE, 32'hFA, 1'b1, 1'b0);
      expect_at(n + 2, "dz_vec",  32'hFF, 32'hFA, 1'b0, 1'b1);
      expect_at(n + 3, "dz_nest", 32'hFF, 32'hFA, 1'b0, 1'b0);
      expect_ack(32'hFF, 32'hFA);
      @(negedge clk);
      set_in(32'h80, 1'b1, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b1, CAUSE_OVFL);
      @(negedge clk);
      set_in(32'h80, 1'b1, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b1, CAUSE_OPCODE);
      @(negedge clk);
      set_in(32'h0, 1'b0, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b0, 2'b00);

      // Reset asserted while the sequencer sits in EXC_EPC.
      @(negedge clk); n = r_edge + 1;
      set_in(32'h0, 1'b0, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b1, CAUSE_OPCODE);
      expect_at(n, "rm_busy", 32'hFF, 32'hFA, 1'b1, 1'b0);
      @(negedge clk);
      set_in(32'h0, 1'b0, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b0, 2'b00);
      #2 reset = 1'b0;
      #1 cmp("rm_now", 32'h0, 32'h0, 1'b0, 1'b0);
      expect_at(r_edge + 1, "rm_hold", 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk); n = r_edge + 1;
      reset = 1'b1;
      expect_at(n, "rm_run", 32'h0, 32'h0, 1'b0, 1'b0);

      // Misaligned write target.
      @(negedge clk); n = r_edge + 1;
      set_in(32'h42, 1'b1, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b0, 2'b00);
`ifdef PC_ALIGN_CHECK_EN
      expect_at(n,     "al_busy", 32'h0,  32'h0,         1'b1, 1'b0);
      expect_at(n + 1, "al_epc",  32'h0,  32'hFFFF_FFFC, 1'b1, 1'b0);
      expect_at(n + 2, "al_vec",  32'hFC, 32'hFFFF_FFFC, 1'b0, 1'b1);
      expect_ack(32'hFC, 32'hFFFF_FFFC);
`else
      expect_at(n,     "al_wr",   32'h42, 32'h0, 1'b0, 1'b0);
      expect_at(n + 2, "al_hold", 32'h42, 32'h0, 1'b0, 1'b0);
`endif
      @(negedge clk);
      set_in(32'h0, 1'b0, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b0, 2'b00);
      repeat (4) @(negedge clk);

      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_vec++;
         n_miss++;
         $display("FAIL %0s: got no check by end, want check at edge %0d", e.name, e.tag);
      end
      while (ack_q.size() > 0) begin
         ack_t a;
         a = ack_q.pop_front();
         n_vec++;
         n_miss++;
         $display("FAIL ack_missing: got no ack, want ack with pc=%h epc=%h", a.pc, a.epc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_update_unit.md
# pc_update_unit

Program-counter register stage fed directly by the PC-source multiplexer's 32-bit output. Holds `pc` and `epc` and decides each cycle whether the mux value is written, using unconditional and branch-conditional write enables. Runs a three-state exception sequence that saves the faulting PC into `epc` and redirects `pc` to a per-cause vector. Its outputs drive instruction-address generation and the PC-source mux's return-from-exception input.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, value of `pc` after reset.
- `VEC_OPCODE`, 32'h0000_00FD, vector for invalid opcode (cause 00).
- `VEC_OVFL`, 32'h0000_00FE, vector for overflow (cause 01).
- `VEC_DIVZ`, 32'h0000_00FF, vector for divide-by-zero (cause 10).
- `VEC_ALIGN`, 32'h0000_00FC, vector for misaligned PC (cause 11). Used only with `PC_ALIGN_CHECK_EN`.

Ports:
- `clk`  in  1  the single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `next_pc`  in  32  candidate PC from the PC-source mux.
- `pc_write`  in  1  unconditional write request.
- `pc_write_cond`  in  1  conditional write request, gated by `branch_op`.
- `branch_op`  in  2  00 BEQ, 01 BNE, 10 BLE, 11 BGT.
- `alu_zero`  in  1  ALU result is zero.
- `alu_lt`  in  1  ALU signed less-than.
- `exc_req`  in  1  exception request, level sampled in RUN.
- `exc_cause`  in  2  cause code, sampled with `exc_req`.
- `pc`  out  32  current PC, registered.
- `epc`  out  32  exception PC, registered.
- `exc_busy`  out  1  high while the FSM is not in RUN.
- `exc_ack`  out  1  one-cycle pulse, high in the first cycle `pc` equals the vector.

## Operation
- Reset values: `pc`=`RESET_PC`, `epc`=0, `exc_busy`=0, `exc_ack`=0, FSM=RUN, latched cause=0.
- Branch condition `take`:
  - BEQ: `alu_zero`.
  - BNE: `!alu_zero`.
  - BLE: `alu_zero | alu_lt`.
  - BGT: `!alu_zero & !alu_lt`.
- Write enable `we` = `pc_write | (pc_write_cond & take)`.
- In RUN with `exc_req`=0 and `we`=1: `pc` <= `next_pc`.
- FSM states:
  - RUN: if `exc_req`=1, latch `exc_cause` and go to EXC_EPC. Any `we` in that cycle is dropped; the exception wins.
  - EXC_EPC: `epc` <= `pc` − 4 (32-bit wrap-around; `pc`=0 gives 32'hFFFF_FFFC). Go to EXC_VEC.
  - EXC_VEC: `pc` <= vector for the latched cause. Go to RUN.
- Cause mapping: 00→`VEC_OPCODE`, 01→`VEC_OVFL`, 10→`VEC_DIVZ`, 11→`VEC_OPCODE` unless `PC_ALIGN_CHECK_EN` is defined.
- Outside RUN, `pc_write`, `pc_write_cond` and `exc_req` are ignored. A nested exception is dropped, not queued.
- `exc_req` still high on return to RUN starts a new sequence.
- Reset asserted mid-sequence: immediate return to reset values. No partial `epc` update survives.

## Timing
- Write path: `we` sampled at edge N; `pc` shows `next_pc` after edge N, a 1-cycle latency.
- Exception path, with `exc_req` sampled at edge N:
  - `exc_busy`=1 after edge N.
  - `epc` valid after edge N+1.
  - `pc`=vector, `exc_busy`=0 and `exc_ack`=1 after edge N+2.
  - `exc_ack` falls after edge N+3.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `PC_ALIGN_CHECK_EN`.
- Defined:
  - In RUN, a `we` with `next_pc[1:0]`≠0 does not write `pc`.
  - It starts the exception sequence with internal cause 11, vector `VEC_ALIGN`.
  - `epc` receives `pc` − 4 as usual.
  - When external `exc_req` and misalignment occur in the same cycle, the external cause wins.
- Undefined: `next_pc` is written unchecked, and cause 11 maps to `VEC_OPCODE`.

## Structure
- Package `pc_unit_pkg` holds:
  - the FSM state enum (RUN, EXC_EPC, EXC_VEC);
  - cause code constants (CAUSE_OPCODE, CAUSE_OVFL, CAUSE_DIVZ, CAUSE_ALIGN);
  - `branch_op` constants (BR_EQ, BR_NE, BR_LE, BR_GT).
- Sub-module: `branch_cond_eval`, combinational. Takes `branch_op`, `alu_zero` and `alu_lt`, and produces `take`.

## Test plan
- Reset: deassert `reset` → `pc`=0, `epc`=0, `exc_busy`=0. Then `pc_write`=1 with `next_pc`=32'h0000_0010 → `pc`=32'h10 one cycle later.
- Conditional writes, each with `next_pc`=32'h40:
  - BNE, `pc_write_cond`=1, `alu_zero`=1 → `pc` unchanged.
  - BGT, `alu_zero`=0, `alu_lt`=0 → `pc`=32'h40.
- Overflow: `pc`=32'h24, `exc_req`=1, cause 01 → `epc`=32'h20 after edge N+1; `pc`=32'hFE with `exc_ack` pulse after edge N+2.
- Simultaneous `exc_req` (cause 10) and `pc_write` (`next_pc`=32'h80) → `pc` never equals 32'h80 and ends at 32'hFF. A second `exc_req` during `exc_busy` is ignored.
- Reset mid-sequence: assert `reset` while in EXC_EPC → `pc`=`RESET_PC`, `epc`=0, `exc_busy`=0 immediately.
- `PC_ALIGN_CHECK_EN` defined, `pc_write` with `next_pc`=32'h42 → `pc`=32'hFC after two further cycles. Undefined → `pc`=32'h42.
